// File: rtl/ccw_rx.sv
// CCW frame receiver: checks LEN/CSUM framing, buffers the payload and drains it over valid/ready.
// Optional inter-byte timeout enabled by defining CCW_RX_TIMEOUT_EN.
module ccw_rx #(
    parameter int unsigned MAX_LEN = 16,
    parameter int unsigned TIMEOUT = 4800,
    parameter int unsigned TW      = 13
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       sof,
    input  logic [7:0] din,
    input  logic       din_vld,
    output logic [7:0] q,
    output logic       q_vld,
    input  logic       q_rdy,
    output logic       q_last,
    output logic       ccw_accepted,
    output logic       ccw_repeat_req,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MaxLen8 = 8'(MAX_LEN);

    if (MAX_LEN < 1 || MAX_LEN > 255) begin : g_bad_max_len
        $error("ccw_rx: MAX_LEN must be 1..255");
    end
    if (TW < 1 || TW > 32 || (TW < 32 && TIMEOUT >= (64'd1 << TW))) begin : g_bad_tw
        $error("ccw_rx: TW too narrow for TIMEOUT");
    end

    typedef enum logic [2:0] {StIdle, StLen, StData, StCsum, StDrain} state_e;

    state_e     state_q, state_d, cur_state;
    logic [7:0] len_q, len_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] widx_q, widx_d;
    logic [7:0] ridx_q, ridx_d;
    logic       acc_q, acc_d;
    logic       rep_q, rep_d;
    logic [1:0] err_q, err_d;
    logic       restart, wr_en, in_rx;
    logic [7:0] mem [2**AW];

    // sof outside DRAIN abandons whatever is in flight and treats this cycle as LEN
    assign restart   = sof && (state_q != StDrain);
    assign cur_state = restart ? StLen : state_q;
    assign in_rx     = state_q inside {StLen, StData, StCsum};

`ifdef CCW_RX_TIMEOUT_EN
    localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT - 1);
    logic [TW-1:0] cnt_q, cnt_d;
    logic          timeout_hit;

    assign cnt_d       = (!in_rx || restart || din_vld) ? '0 : cnt_q + 1'b1;
    assign timeout_hit = in_rx && !restart && !din_vld && (cnt_q == TimeoutLast);

    always_ff @(posedge clk) begin
        if (!n_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic timeout_hit;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sum_d   = sum_q;
        widx_d  = widx_q;
        ridx_d  = ridx_q;
        acc_d   = 1'b0;
        rep_d   = 1'b0;
        err_d   = err_q;
        wr_en   = 1'b0;
        case (cur_state)
            StIdle: ;
            StLen: begin
                state_d = StLen;
                if (din_vld) begin
                    if (din == 8'd0 || din > MaxLen8) begin
                        state_d = StIdle;
                        rep_d   = 1'b1;
                        err_d   = 2'd1;
                    end else begin
                        state_d = StData;
                        len_d   = din;
                        sum_d   = din;
                        widx_d  = 8'd0;
                    end
                end
            end
            StData: begin
                if (din_vld) begin
                    wr_en  = 1'b1;
                    sum_d  = sum_q + din;
                    widx_d = widx_q + 8'd1;
                    if (widx_q == len_q - 8'd1) state_d = StCsum;
                end
            end
            StCsum: begin
                if (din_vld) begin
                    if (din == sum_q) begin
                        state_d = StDrain;
                        acc_d   = 1'b1;
                        ridx_d  = 8'd0;
                    end else begin
                        state_d = StIdle;
                        rep_d   = 1'b1;
                        err_d   = 2'd2;
                    end
                end
            end
            StDrain: begin
                // overrun: the new frame is dropped, the drain carries on
                if (sof) begin
                    rep_d = 1'b1;
                    err_d = 2'd0;
                end
                if (q_rdy) begin
                    if (ridx_q == len_q - 8'd1) begin
                        state_d = StIdle;
                        ridx_d  = 8'd0;
                    end else begin
                        ridx_d = ridx_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (timeout_hit) begin
            state_d = StIdle;
            rep_d   = 1'b1;
            err_d   = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= StIdle;
            len_q   <= 8'd0;
            sum_q   <= 8'd0;
            widx_q  <= 8'd0;
            ridx_q  <= 8'd0;
            acc_q   <= 1'b0;
            rep_q   <= 1'b0;
            err_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            widx_q  <= widx_d;
            ridx_q  <= ridx_d;
            acc_q   <= acc_d;
            rep_q   <= rep_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (n_rst && wr_en) mem[widx_q[AW-1:0]] <= din;
    end

    assign q_vld          = (state_q == StDrain);
    assign q              = q_vld ? mem[ridx_q[AW-1:0]] : 8'd0;
    assign q_last         = q_vld && (ridx_q == len_q - 8'd1);
    assign ccw_accepted   = acc_q;
    assign ccw_repeat_req = rep_q;
    assign err_code       = err_q;
    assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_ccw_rx.sv
// Self-checking bench for ccw_rx: scoreboard of expected drained bytes plus pulse/err monitors.
// Timeout scenario follows CCW_RX_TIMEOUT_EN.
module tb_ccw_rx;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] din = 8'd0;
    logic       din_vld = 1'b0;
    logic [7:0] q;
    logic       q_vld;
    logic       q_rdy = 1'b0;
    logic       q_last;
    logic       ccw_accepted;
    logic       ccw_repeat_req;
    logic [1:0] err_code;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    int rep_cnt = 0;
    int qvld_cycles = 0;
    logic [1:0] last_err = 2'd0;
    logic [8:0] exp_q[$];
    logic [7:0] pl[$];
    logic       hold_pending = 1'b0;
    logic [7:0] held_q = 8'd0;

    ccw_rx dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .sof           (sof),
        .din           (din),
        .din_vld       (din_vld),
        .q             (q),
        .q_vld         (q_vld),
        .q_rdy         (q_rdy),
        .q_last        (q_last),
        .ccw_accepted  (ccw_accepted),
        .ccw_repeat_req(ccw_repeat_req),
        .err_code      (err_code),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // monitor: pulse bookkeeping, stability under backpressure, scoreboard pops
    always @(negedge clk) begin
        if (!n_rst) begin
            hold_pending = 1'b0;
        end else begin
            if (ccw_accepted) begin
                acc_cnt++;
                checks++;
                if (!q_vld) begin
                    errors++;
                    $display("FAIL accept_qvld: q_vld=%0b required 1", q_vld);
                end
            end
            if (ccw_repeat_req) begin
                rep_cnt++;
                last_err = err_code;
            end
            if (ccw_accepted && ccw_repeat_req) begin
                errors++;
                $display("FAIL pulse_exclusive: both pulses high");
            end
            if (q_vld) qvld_cycles++;
            if (hold_pending) begin
                checks++;
                if (!q_vld || q !== held_q) begin
                    errors++;
                    $display("FAIL hold_stable: q_vld=%0b q=%h required 1/%h", q_vld, q, held_q);
                end
            end
            hold_pending = q_vld && !q_rdy;
            held_q = q;
            if (q_vld && q_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL drain_unexpected: q=%h last=%0b with empty scoreboard", q, q_last);
                end else begin
                    automatic logic [8:0] e = exp_q.pop_front();
                    if ({q_last, q} !== e) begin
                        errors++;
                        $display("FAIL drain_byte: last/q=%0b/%h required %0b/%h",
                                 q_last, q, e[8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic [7:0] b);
        sof = s;
        din_vld = v;
        din = b;
        cycle();
        sof = 1'b0;
        din_vld = 1'b0;
    endtask

    task automatic send_frame(input logic bad, input logic expect_good);
        logic [7:0] sum;
        sum = 8'(pl.size());
        if (expect_good)
            foreach (pl[i]) exp_q.push_back({(i == pl.size() - 1), pl[i]});
        drive(1'b1, 1'b0, 8'd0);
        drive(1'b0, 1'b1, 8'(pl.size()));
        foreach (pl[i]) begin
            sum = sum + pl[i];
            drive(1'b0, 1'b1, pl[i]);
        end
        drive(1'b0, 1'b1, bad ? sum + 8'd1 : sum);
    endtask

    task automatic wait_idle(input int budget, input logic random_rdy);
        int n = 0;
        while (busy && n < budget) begin
            if (random_rdy) q_rdy = 1'($urandom_range(0, 1));
            cycle();
            n++;
        end
        cycle();
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles", budget);
        end
    endtask

    task automatic clear_counts();
        acc_cnt = 0;
        rep_cnt = 0;
        qvld_cycles = 0;
    endtask

    task automatic apply_reset();
        n_rst = 1'b0;
        cycle();
        n_rst = 1'b1;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        cycle();
        cycle();
        checks++;
        if ({q_vld, busy, err_code, q, q_last, ccw_accepted, ccw_repeat_req} !== 15'd0) begin
            errors++;
            $display("FAIL reset_state: vld/busy/err/q/last/acc/rep=%0b/%0b/%0d/%h/%0b/%0b/%0b required all 0",
                     q_vld, busy, err_code, q, q_last, ccw_accepted, ccw_repeat_req);
        end
        n_rst = 1'b1;
        cycle();
    endtask

    task automatic test_good_frame();
        clear_counts();
        q_rdy = 1'b1;
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(1'b0, 1'b1);
        wait_idle(20, 1'b0);
        checks++;
        if (acc_cnt != 1 || rep_cnt != 0) begin
            errors++;
            $display("FAIL good_pulses: acc=%0d rep=%0d required 1/0", acc_cnt, rep_cnt);
        end
        checks++;
        if (exp_q.size() != 0 || qvld_cycles != 3) begin
            errors++;
            $display("FAIL good_drain: left=%0d qvld_cycles=%0d required 0/3", exp_q.size(), qvld_cycles);
        end
    endtask

    task automatic test_bad_checksum();
        clear_counts();
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(1'b1, 1'b0);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL csum_busy: busy=%0b required 0", busy);
        end
        cycle();
        cycle();
        checks++;
        if (rep_cnt != 1 || last_err != 2'd2 || acc_cnt != 0 || qvld_cycles != 0) begin
            errors++;
            $display("FAIL bad_csum: rep=%0d err=%0d acc=%0d qvld=%0d required 1/2/0/0",
                     rep_cnt, last_err, acc_cnt, qvld_cycles);
        end
    endtask

    task automatic test_bad_length();
        logic [7:0] lens [2];
        lens[0] = 8'h00;
        lens[1] = 8'h11;
        for (int k = 0; k < 2; k++) begin
            clear_counts();
            last_err = 2'd3;
            drive(1'b1, 1'b0, 8'd0);
            drive(1'b0, 1'b1, lens[k]);
            drive(1'b0, 1'b1, 8'h01);
            drive(1'b0, 1'b1, 8'h02);
            cycle();
            checks++;
            if (rep_cnt != 1 || last_err != 2'd1 || acc_cnt != 0) begin
                errors++;
                $display("FAIL bad_len_%0d: rep=%0d err=%0d acc=%0d required 1/1/0",
                         k, rep_cnt, last_err, acc_cnt);
            end
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL bad_len_ignore_%0d: busy=%0b required 0", k, busy);
            end
        end
    endtask

    task automatic test_abort();
        clear_counts();
        q_rdy = 1'b1;
        drive(1'b1, 1'b0, 8'd0);
        drive(1'b0, 1'b1, 8'h03);
        drive(1'b0, 1'b1, 8'h11);
        drive(1'b0, 1'b1, 8'h22);
        pl = '{8'hAA};
        send_frame(1'b0, 1'b1);
        wait_idle(20, 1'b0);
        checks++;
        if (acc_cnt != 1 || rep_cnt != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL abort: acc=%0d rep=%0d left=%0d required 1/0/0", acc_cnt, rep_cnt, exp_q.size());
        end
        // sof and LEN in the same cycle
        clear_counts();
        drive(1'b1, 1'b1, 8'h01);
        drive(1'b0, 1'b1, 8'h44);
        exp_q.push_back({1'b1, 8'h44});
        drive(1'b0, 1'b1, 8'h45);
        wait_idle(20, 1'b0);
        checks++;
        if (acc_cnt != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL sof_with_len: acc=%0d left=%0d required 1/0", acc_cnt, exp_q.size());
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        clear_counts();
        drive(1'b1, 1'b0, 8'd0);
        drive(1'b0, 1'b1, 8'h02);
        drive(1'b0, 1'b1, 8'h55);
`ifdef CCW_RX_TIMEOUT_EN
        while (rep_cnt == 0 && n < 6000) begin
            cycle();
            n++;
        end
        checks++;
        if (rep_cnt != 1 || last_err != 2'd3 || n < 4790 || n > 4810) begin
            errors++;
            $display("FAIL timeout: rep=%0d err=%0d after=%0d required 1/3/~4800", rep_cnt, last_err, n);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: busy=%0b required 0", busy);
        end
`else
        for (n = 0; n < 10000; n++) cycle();
        checks++;
        if (rep_cnt != 0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL no_timeout: rep=%0d busy=%0b required 0/1", rep_cnt, busy);
        end
        apply_reset();
`endif
    endtask

    task automatic test_back_to_back();
        clear_counts();
        q_rdy = 1'b0;
        pl = '{8'h01, 8'h80, 8'hFF, 8'h7E, 8'h10};
        send_frame(1'b0, 1'b1);
        wait_idle(300, 1'b1);
        q_rdy = 1'b0;
        pl = '{8'hC3, 8'h3C};
        send_frame(1'b0, 1'b1);
        wait_idle(300, 1'b1);
        checks++;
        if (acc_cnt != 2 || rep_cnt != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL back_to_back: acc=%0d rep=%0d left=%0d required 2/0/0",
                     acc_cnt, rep_cnt, exp_q.size());
        end
    endtask

    task automatic test_overrun_reset();
        clear_counts();
        last_err = 2'd3;
        q_rdy = 1'b0;
        pl = '{8'h10, 8'h20};
        send_frame(1'b0, 1'b1);
        pl = '{8'h05};
        send_frame(1'b0, 1'b0);
        cycle();
        checks++;
        if (rep_cnt != 1 || last_err != 2'd0 || acc_cnt != 1) begin
            errors++;
            $display("FAIL overrun: rep=%0d err=%0d acc=%0d required 1/0/1", rep_cnt, last_err, acc_cnt);
        end
        checks++;
        if (q_vld !== 1'b1 || q !== 8'h10 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL overrun_hold: vld=%0b q=%h err=%0d required 1/10/0", q_vld, q, err_code);
        end
        // force a non-zero err_code so the reset clearing it is observable
        pl = '{8'h01};
        apply_reset();
        exp_q.delete();
        send_frame(1'b1, 1'b0);
        cycle();
        checks++;
        if (err_code !== 2'd2) begin
            errors++;
            $display("FAIL err_before_reset: err=%0d required 2", err_code);
        end
        q_rdy = 1'b0;
        pl = '{8'h66};
        send_frame(1'b0, 1'b0);
        n_rst = 1'b0;
        cycle();
        checks++;
        if (q_vld !== 1'b0 || busy !== 1'b0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_drain: vld=%0b busy=%0b err=%0d required 0/0/0",
                     q_vld, busy, err_code);
        end
        n_rst = 1'b1;
        cycle();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_length();
        test_abort();
        test_timeout();
        test_back_to_back();
        test_overrun_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
